mem_stream_host: RTL and testbench

//  External-memory-side counterpart of the accelerator chip's streaming interface.
//  - Reads activation and weight words from a single-read-port external memory.
//  - Drives them to the chip over two valid/ready streams.
//  - Pulses the chip start.
//  - Writes every chip output word back to memory.
//  - Sits beside the chip inside the system wrapper; every word counted as chip bandwidth passes through it.

---
 rtl/mem_stream_host.sv | 208 ++++++++++++++++++++
 tb/tb_mem_stream_host.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_host.sv
// Memory-side streaming host. It reads activation and weight words from external memory,
// streams them to the chip, and writes the chip outputs back. MEM_STREAM_BW_COUNT_EN adds bandwidth counters.

module mem_stream_fifo #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_in,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [1:0][W-1:0] mem;
  logic              rd_ptr, wr_ptr;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      mem    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign valid = (count != 2'd0);
  assign head  = valid ? mem[rd_ptr] : '0;
endmodule

module mem_stream_host #(
  parameter int MEM_BW          = 128,
  parameter int ADDR_WIDTH      = 16,
  parameter int NB_ACT_WORDS    = 256,
  parameter int NB_WEIGHT_WORDS = 36,
  parameter int NB_OUT_WORDS    = 256
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  host_start,
  input  logic [ADDR_WIDTH-1:0] act_base,
  input  logic [ADDR_WIDTH-1:0] wt_base,
  input  logic [ADDR_WIDTH-1:0] out_base,
  output logic                  host_done,
  output logic                  out_overflow,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [MEM_BW-1:0]     mem_rd_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [MEM_BW-1:0]     mem_wr_data,
  output logic [MEM_BW-1:0]     activations_output,
  output logic                  activations_valid,
  input  logic                  activations_ready,
  output logic [MEM_BW-1:0]     weights_output,
  output logic                  weights_valid,
  input  logic                  weights_ready,
  input  logic [MEM_BW-1:0]     chip_out,
  input  logic                  chip_output_valid,
  output logic                  chip_start,
`ifdef MEM_STREAM_BW_COUNT_EN
  output logic [31:0]           bw_rd_words,
  output logic [31:0]           bw_wr_words,
`endif
  input  logic                  chip_running
);
  localparam int NS     = 2;  // stream 0 = activations, 1 = weights
  localparam int NB_MAX = (NB_ACT_WORDS > NB_WEIGHT_WORDS) ? NB_ACT_WORDS : NB_WEIGHT_WORDS;
  localparam int IW     = $clog2(NB_MAX + 1);
  localparam int OW     = $clog2(NB_OUT_WORDS + 1);
  localparam logic [NS-1:0][IW-1:0] NB_RD = {IW'(NB_WEIGHT_WORDS), IW'(NB_ACT_WORDS)};

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t                         state, state_nxt;
  logic [NS-1:0][ADDR_WIDTH-1:0]  rd_base;
  logic [ADDR_WIDTH-1:0]          out_base_q;
  logic [NS-1:0][IW-1:0]          rd_idx;
  logic                           rd_inflight, rd_tag, rr_pref;
  logic [OW-1:0]                  out_cnt;
  logic [NS-1:0]                  elig, rd_left, inflight, push, pop, fvld, rdy;
  logic [NS-1:0][1:0]             fcnt;
  logic [NS-1:0][MEM_BW-1:0]      fhead;
  logic                           rd_gnt, accept, rd_phase, streams_done, wr_ok;

  assign accept   = (state == IDLE) && host_start;
  assign rd_phase = (state == START) || (state == RUN);
  assign rdy      = {weights_ready, activations_ready};

  for (genvar s = 0; s < NS; s++) begin : g_stream
    mem_stream_fifo #(.W(MEM_BW)) u_fifo (
      .clk       (clk),
      .rst_in    (rst_in),
      .push      (push[s]),
      .push_data (mem_rd_data),
      .pop       (pop[s]),
      .valid     (fvld[s]),
      .head      (fhead[s]),
      .count     (fcnt[s])
    );
  end

  // A stream may not have more than two words buffered or in flight.
  always_comb begin
    rd_left  = '0;
    inflight = '0;
    push     = '0;
    pop      = '0;
    elig     = '0;
    for (int s = 0; s < NS; s++) begin
      rd_left[s]  = (rd_idx[s] != NB_RD[s]);
      inflight[s] = rd_inflight && (rd_tag == 1'(s));
      push[s]     = inflight[s];
      pop[s]      = fvld[s] && rdy[s];
      elig[s]     = rd_phase && rd_left[s] && (({1'b0, fcnt[s]} + {2'b0, inflight[s]}) < 3'd2);
    end
  end

  assign rd_gnt       = (&elig) ? rr_pref : elig[1];
  assign mem_rd_en    = |elig;
  assign mem_rd_addr  = mem_rd_en ? rd_base[rd_gnt] + ADDR_WIDTH'(rd_idx[rd_gnt]) : '0;
  assign streams_done = ~|rd_left && !rd_inflight && ~|fvld;

  assign activations_output = fhead[0];
  assign activations_valid  = fvld[0];
  assign weights_output     = fhead[1];
  assign weights_valid      = fvld[1];

  assign wr_ok       = rd_phase && chip_output_valid && (out_cnt != OW'(NB_OUT_WORDS));
  assign mem_wr_en   = wr_ok;
  assign mem_wr_addr = wr_ok ? out_base_q + ADDR_WIDTH'(out_cnt) : '0;
  assign mem_wr_data = wr_ok ? chip_out : '0;

  always_ff @(posedge clk) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (host_start) state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     if (streams_done && (out_cnt == OW'(NB_OUT_WORDS)) && !chip_running) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    chip_start = (state == START);
    host_done  = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      rd_base      <= '0;
      out_base_q   <= '0;
      rd_idx       <= '0;
      rd_inflight  <= 1'b0;
      rd_tag       <= 1'b0;
      rr_pref      <= 1'b1;
      out_cnt      <= '0;
      out_overflow <= 1'b0;
    end else begin
      rd_inflight <= mem_rd_en;
      rd_tag      <= rd_gnt;
      if (accept) begin
        rd_base      <= {wt_base, act_base};
        out_base_q   <= out_base;
        rd_idx       <= '0;
        rr_pref      <= 1'b1;
        out_cnt      <= '0;
        out_overflow <= 1'b0;
      end
      if (mem_rd_en) begin
        rd_idx[rd_gnt] <= rd_idx[rd_gnt] + IW'(1);
        rr_pref        <= ~rd_gnt;
      end
      if (wr_ok) out_cnt <= out_cnt + OW'(1);
      else if (rd_phase && chip_output_valid) out_overflow <= 1'b1;
    end
  end

`ifdef MEM_STREAM_BW_COUNT_EN
  logic [32:0] bw_rd_sum, bw_wr_sum;
  assign bw_rd_sum = {1'b0, bw_rd_words} + 33'(pop[0]) + 33'(pop[1]);
  assign bw_wr_sum = {1'b0, bw_wr_words} + 33'(wr_ok);

  always_ff @(posedge clk) begin
    if (rst_in || accept) begin
      bw_rd_words <= '0;
      bw_wr_words <= '0;
    end else begin
      bw_rd_words <= bw_rd_sum[32] ? '1 : bw_rd_sum[31:0];
      bw_wr_words <= bw_wr_sum[32] ? '1 : bw_wr_sum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_mem_stream_host.sv
// Directed bench for mem_stream_host with a small run size (4 act, 2 wt, 4 out words).
// It uses a behavioural memory, a scripted chip and a negedge monitor.
module tb_mem_stream_host;
  localparam int NA = 4, NW = 2, NO = 4;

  logic         clk = 1'b0, rst_in = 1'b1, host_start = 1'b0;
  logic [15:0]  act_base = '0, wt_base = '0, out_base = '0;
  logic         host_done, out_overflow, mem_rd_en, mem_wr_en, chip_start;
  logic [15:0]  mem_rd_addr, mem_wr_addr;
  logic [127:0] mem_rd_data = '0, mem_wr_data, activations_output, weights_output;
  logic         activations_valid, weights_valid;
  logic         activations_ready = 1'b1, weights_ready = 1'b1;
  logic [127:0] chip_out = '0;
  logic         chip_output_valid = 1'b0, chip_running = 1'b0;
`ifdef MEM_STREAM_BW_COUNT_EN
  logic [31:0]  bw_rd_words, bw_wr_words;
`endif

  mem_stream_host #(.MEM_BW(128), .ADDR_WIDTH(16), .NB_ACT_WORDS(NA),
                    .NB_WEIGHT_WORDS(NW), .NB_OUT_WORDS(NO)) dut (
    .clk(clk), .rst_in(rst_in), .host_start(host_start),
    .act_base(act_base), .wt_base(wt_base), .out_base(out_base),
    .host_done(host_done), .out_overflow(out_overflow),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .activations_output(activations_output), .activations_valid(activations_valid),
    .activations_ready(activations_ready),
    .weights_output(weights_output), .weights_valid(weights_valid), .weights_ready(weights_ready),
    .chip_out(chip_out), .chip_output_valid(chip_output_valid), .chip_start(chip_start),
`ifdef MEM_STREAM_BW_COUNT_EN
    .bw_rd_words(bw_rd_words), .bw_wr_words(bw_wr_words),
`endif
    .chip_running(chip_running));

  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input logic [15:0] a);
    return {a, 96'h0123_4567_89AB_CDEF_0246_8ACE, a};
  endfunction

  function automatic logic [127:0] cpat(input int i);
    return {4{32'(i) ^ 32'h5A5A_C0DE}};
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_rd_data <= mem_rd_en ? pat(mem_rd_addr) : 128'h0;

  // monitor
  logic [15:0]  rd_q[$], wr_addr_q[$];
  logic [127:0] act_q[$], wt_q[$], wr_data_q[$];
  int done_cnt = 0, cs_cnt = 0, cs_cyc = 0, stab_err = 0, wt_rd = 0, wt_pop = 0, wt_max_out = 0;
  logic [15:0]  cur_wb = '0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_wd = '0;

  always @(negedge clk) begin
    if (mem_rd_en) begin
      rd_q.push_back(mem_rd_addr);
      if (16'(mem_rd_addr - cur_wb) < 16'(NW)) wt_rd++;
    end
    if (activations_valid && activations_ready) act_q.push_back(activations_output);
    if (weights_valid && weights_ready) begin
      wt_q.push_back(weights_output);
      wt_pop++;
    end
    if (wt_rd - wt_pop > wt_max_out) wt_max_out = wt_rd - wt_pop;
    if (mem_wr_en) begin
      wr_addr_q.push_back(mem_wr_addr);
      wr_data_q.push_back(mem_wr_data);
    end
    if (host_done) done_cnt++;
    if (chip_start) begin
      cs_cnt++;
      cs_cyc = cyc;
    end
    if (weights_valid && !weights_ready) begin
      if (prev_stall && weights_output !== prev_wd) stab_err++;
      prev_stall = 1'b1;
      prev_wd    = weights_output;
    end else prev_stall = 1'b0;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, 128'({host_done, out_overflow, mem_rd_en, mem_wr_en,
                              activations_valid, weights_valid, chip_start}), 128'h0);
    chk({tag, "_addr"}, 128'({mem_rd_addr, mem_wr_addr}), 128'h0);
    chk({tag, "_wdata"}, mem_wr_data, 128'h0);
    chk({tag, "_sdata"}, activations_output | weights_output, 128'h0);
  endtask

  task automatic run(input string tag, input logic [15:0] ab, input logic [15:0] wb,
                     input logic [15:0] ob, input int n_out, input int stall);
    int r0, a0, w0, k0, d0, c0, hs, sent, n_act_rd, n_wr;
    logic [15:0] act_addrs[$];
    r0 = rd_q.size(); a0 = act_q.size(); w0 = wt_q.size(); k0 = wr_addr_q.size();
    d0 = done_cnt; c0 = cs_cnt; sent = 0;
    act_base = ab; wt_base = wb; out_base = ob; cur_wb = wb;
    host_start = 1'b1; hs = cyc;
    @(posedge clk); #1;
    host_start = 1'b0;
    for (int c = 0; c < 400 && done_cnt == d0; c++) begin
      weights_ready = (c >= stall);
      if (stall > 0 && c == stall) begin
        chk({tag, "_stall_wvalid_held"}, 128'(weights_valid), 128'h1);
        chk({tag, "_stall_act_flow"}, 128'(act_q.size() - a0), 128'(NA));
      end
      if (cs_cnt != c0 && sent < n_out) begin
        chip_output_valid = 1'b1;
        chip_out = cpat(sent);
        sent++;
      end else begin
        chip_output_valid = 1'b0;
        chip_out = '0;
      end
      chip_running = (cs_cnt != c0) && (chip_output_valid || sent < n_out ||
                     act_q.size() - a0 < NA || wt_q.size() - w0 < NW);
      @(posedge clk); #1;
    end
    chip_output_valid = 1'b0; chip_running = 1'b0; weights_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_host_done_once"}, 128'(done_cnt - d0), 128'h1);
    chk({tag, "_chip_start_once"}, 128'(cs_cnt - c0), 128'h1);
    chk({tag, "_chip_start_cycle"}, 128'(cs_cyc - hs), 128'h1);
    chk({tag, "_first_read_wt"}, 128'(rd_q.size() > r0 ? rd_q[r0] : 16'hDEAD), 128'(wb));
    chk({tag, "_act_cnt"}, 128'(act_q.size() - a0), 128'(NA));
    chk({tag, "_wt_cnt"}, 128'(wt_q.size() - w0), 128'(NW));
    for (int i = 0; i < NA && a0 + i < act_q.size(); i++)
      chk($sformatf("%s_act%0d", tag, i), act_q[a0+i], pat(16'(ab + 16'(i))));
    for (int i = 0; i < NW && w0 + i < wt_q.size(); i++)
      chk($sformatf("%s_wt%0d", tag, i), wt_q[w0+i], pat(16'(wb + 16'(i))));
    for (int i = r0; i < rd_q.size(); i++)
      if (16'(rd_q[i] - wb) >= 16'(NW)) act_addrs.push_back(rd_q[i]);
    n_act_rd = act_addrs.size();
    chk({tag, "_act_rd_cnt"}, 128'(n_act_rd), 128'(NA));
    for (int i = 0; i < NA && i < n_act_rd; i++)
      chk($sformatf("%s_act_addr%0d", tag, i), 128'(act_addrs[i]), 128'(16'(ab + 16'(i))));
    n_wr = (n_out < NO) ? n_out : NO;
    chk({tag, "_wr_cnt"}, 128'(wr_addr_q.size() - k0), 128'(n_wr));
    for (int i = 0; i < n_wr && k0 + i < wr_addr_q.size(); i++) begin
      chk($sformatf("%s_wr_addr%0d", tag, i), 128'(wr_addr_q[k0+i]), 128'(16'(ob + 16'(i))));
      chk($sformatf("%s_wr_data%0d", tag, i), wr_data_q[k0+i], cpat(i));
    end
    chk({tag, "_overflow"}, 128'(out_overflow), 128'(n_out > NO));
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst_in = 1'b0;
    @(posedge clk); #1;
    chk_idle("post_reset");

    run("basic", 16'h0100, 16'h0200, 16'h0300, 4, 0);
`ifdef MEM_STREAM_BW_COUNT_EN
    chk("bw_rd_basic", 128'(bw_rd_words), 128'd6);
    chk("bw_wr_basic", 128'(bw_wr_words), 128'd4);
`endif
    run("stall", 16'h1000, 16'h2000, 16'h3000, 4, 10);
    chk("stall_data_stable", 128'(stab_err), 128'h0);
    chk("stall_wt_outstanding_le2", 128'(wt_max_out <= 2), 128'h1);
    run("wrap", 16'hFFFE, 16'h0100, 16'h0400, 4, 0);
    run("ovf", 16'h0500, 16'h0600, 16'h0700, 5, 0);
`ifdef MEM_STREAM_BW_COUNT_EN
    chk("bw_wr_ovf", 128'(bw_wr_words), 128'd4);
`endif
    run("ovf_clear", 16'h0800, 16'h0900, 16'h0A00, 4, 0);

    // reset in the middle of a run while a read is outstanding
    activations_ready = 1'b0; weights_ready = 1'b0;
    act_base = 16'h5000; wt_base = 16'h6000; out_base = 16'h7000; cur_wb = 16'h6000;
    d0 = done_cnt;
    host_start = 1'b1;
    @(posedge clk); #1;
    host_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_rd_en) break;
    end
    chk("rst_read_seen", 128'(mem_rd_en), 128'h1);
    rst_in = 1'b1;
    @(posedge clk); #1;
    chk_idle("rst_mid");
    rst_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_idle("rst_after");
    chk("rst_no_done", 128'(done_cnt - d0), 128'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
